// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared limits and tag types for the ROM read-port arbiter
package rom_arb_pkg;

    localparam int ROM_ARB_MAX_REQ = 8;
    localparam int ROM_ARB_MAX_LAT = 4;

    typedef logic [2:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rom_arb_rr_pick.sv
// rtl/rom_arb_rr_pick.sv - rotate-and-find-first picker; the first set bit at or after start wins
module rom_arb_rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            start,
    output logic               found,
    output req_id_t            winner
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;
    int                   sum;

    assign doubled = {req, req};
    assign rotated = doubled >> start;

    // Bit k of the rotated vector is requester (start + k) mod NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = int'(start) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                winner = req_id_t'(sum);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares the synchronous ROM read port among NUM_REQ requesters
// Optional: ROM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_W-1:0]              resp_data,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_rdata
);

    logic              found;
    logic              grant;
    req_id_t           winner;
    req_id_t           start;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    tag_t              tag_q [MEM_LATENCY];
    tag_t              tag_in;
    tag_t              tag_out;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    req_id_t last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= req_id_t'(NUM_REQ - 1);
        end else if (grant) begin
            last_grant <= winner;
        end
    end

    assign start = (last_grant == req_id_t'(NUM_REQ - 1)) ? '0 : req_id_t'(last_grant + req_id_t'(1));
`endif

    rom_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .start  (start),
        .found  (found),
        .winner (winner)
    );

    assign grant = found && !reset;

    // Idle cycles keep presenting the last granted address so the ROM input stays stable.
    always_comb begin
        req_ready = '0;
        mem_addr  = addr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && winner == req_id_t'(i)) begin
                req_ready[i] = 1'b1;
                mem_addr     = req_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else if (grant) begin
            addr_q <= mem_addr;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = grant;
        tag_in.id    = winner;
    end

    // Tags advance every cycle so a grant's id emerges exactly when its ROM data does.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out = tag_q[MEM_LATENCY-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_out.valid && (tag_out.id == req_id_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (tag_out.valid) begin
            data_q <= mem_rdata;
        end
    end

    assign resp_data = tag_out.valid ? mem_rdata : data_q;

endmodule
